// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch and load/store.
// Optional bus-wait timeout enabled by defining BUS_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          bus_err,
    output logic          busy,
    output logic          MREQ,
    output logic          WRITE,
    output logic [1:0]    SIZE,
    output logic [AW-1:0] BAD,
    output logic [DW-1:0] BWDT,
    input  logic [DW-1:0] BRDT,
    input  logic          ACK_n
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
    typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t;

    state_t state;
    grant_t last_grant;
    logic   if_pend;
    logic   d_pend;
    logic   grant_if;
    logic   grant_d;
    logic   timeout;
    logic   done;

    // A requester still holds req during its own ack pulse, so that port is
    // not considered pending again until the pulse has passed.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        if_pend  = if_req && !if_ack;
        d_pend   = d_req && !d_ack;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (if_pend && (!d_pend || last_grant == GRANT_DATA)) begin
            grant_if = 1'b1;
        end else if (d_pend) begin
            grant_d = 1'b1;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    // Held at zero while idle, so it is already clear on entry to FETCH/DATA.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            wait_cnt <= '0;
        end else if (ACK_n) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign timeout = (state != IDLE) && ACK_n && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign done = !ACK_n || timeout;

    always_ff @(posedge clk) begin
        // NOTE: registers are written with non-blocking assignments so every
        // right-hand side sees the pre-edge value, whatever the statement order.
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_DATA;
            if_ack     <= 1'b0;
            if_rdata   <= '0;
            d_ack      <= 1'b0;
            d_rdata    <= '0;
            bus_err    <= 1'b0;
            busy       <= 1'b0;
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            SIZE       <= 2'b00;
            BAD        <= '0;
            BWDT       <= '0;
        end else begin
            if_ack  <= 1'b0;
            d_ack   <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_if) begin
                        state      <= FETCH;
                        last_grant <= GRANT_FETCH;
                        busy       <= 1'b1;
                        MREQ       <= 1'b1;
                        WRITE      <= 1'b0;
                        SIZE       <= 2'b00;
                        BAD        <= if_addr;
                        BWDT       <= '0;
                    end else if (grant_d) begin
                        state      <= DATA;
                        last_grant <= GRANT_DATA;
                        busy       <= 1'b1;
                        MREQ       <= 1'b1;
                        WRITE      <= d_we;
                        SIZE       <= d_size;
                        BAD        <= d_addr;
                        BWDT       <= d_we ? d_wdata : '0;
                    end
                end
                FETCH, DATA: begin
                    if (done) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        MREQ    <= 1'b0;
                        WRITE   <= 1'b0;
                        SIZE    <= 2'b00;
                        BAD     <= '0;
                        BWDT    <= '0;
                        bus_err <= timeout;
                        if (state == FETCH) begin
                            if_ack   <= 1'b1;
                            if_rdata <= timeout ? '0 : BRDT;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= (timeout || d_we) ? '0 : BRDT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
